// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and OPMODE field encodings for the DSP48A1 MAC sequencer.
// OPMODE layout used here: [1:0] = X mux select, [3:2] = Z mux select, upper bits zero.
package dsp_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;

    function automatic logic [7:0] make_opmode(input logic [1:0] z, input logic [1:0] x);
        return {4'b0000, z, x};
    endfunction

    localparam logic [7:0] OPM_FIRST_DEF = make_opmode(Z_ZERO, X_M);
    localparam logic [7:0] OPM_ACC_DEF   = make_opmode(Z_P, X_M);

endpackage

// File: rtl/dsp_valid_pipe.sv
// Two-stage {valid, first, last} shift register tracking beats through the slice M and P registers.
// Drives ce_m/ce_p and selects OPMODE for the P stage; flush drops everything in flight.
module dsp_valid_pipe
    import dsp_mac_sequencer_pkg::*;
#(
    parameter logic [7:0] OPM_FIRST = OPM_FIRST_DEF,
    parameter logic [7:0] OPM_ACC   = OPM_ACC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_v,
    input  logic       in_f,
    input  logic       in_l,
    output logic       ce_m,
    output logic       ce_p,
    output logic [7:0] opmode,
    output logic       l2
);

    logic v1, f1, l1;
    logic v2, f2, l2_q;

    // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1   <= 1'b0;
            f1   <= 1'b0;
            l1   <= 1'b0;
            v2   <= 1'b0;
            f2   <= 1'b0;
            l2_q <= 1'b0;
        end else begin
            v1   <= in_v;
            f1   <= in_f;
            l1   <= in_l;
            v2   <= v1;
            f2   <= f1;
            l2_q <= l1;
        end
    end

    assign ce_m   = v1;
    assign ce_p   = v2;
    assign l2     = l2_q;
    assign opmode = v2 ? (f2 ? OPM_FIRST : OPM_ACC) : 8'h00;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (AREG=BREG=MREG=PREG=1) through an N-term multiply-accumulate.
// Accepts operand beats via valid/ready, drives the slice clock enables/OPMODE, pulses done on the final P.
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int         LEN_W     = 8,
    parameter logic [7:0] OPM_FIRST = OPM_FIRST_DEF,
    parameter logic [7:0] OPM_ACC   = OPM_ACC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic [7:0]       opmode,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             first;
    logic             accept;
    logic             last;
    logic             l2;

    // Ready is combinational so a beat lands in the A/B registers on the same edge it is accepted.
    assign in_ready = (state == ACC) && !abort && !rst;
    assign accept   = in_valid && in_ready;
    assign ce_ab    = accept;
    assign last     = (cnt == LEN_W'(1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            first <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
                first <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && len != '0) begin
                            state <= ACC;
                            cnt   <= len;
                            first <= 1'b1;
                        end
                    end
                    ACC: begin
                        if (accept) begin
                            cnt   <= cnt - LEN_W'(1);
                            first <= 1'b0;
                            if (last) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // The last beat sits in the P-enable stage now; P is final next cycle.
                        if (l2) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    dsp_valid_pipe #(
        .OPM_FIRST (OPM_FIRST),
        .OPM_ACC   (OPM_ACC)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush  (abort),
        .in_v   (accept),
        .in_f   (first),
        .in_l   (accept && last),
        .ce_m   (ce_m),
        .ce_p   (ce_p),
        .opmode (opmode),
        .l2     (l2)
    );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice (A/B, M, P registers).
// Expected cycle offsets, OPMODE sequences and P results are hand-computed per scenario.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic        ce_ab;
    logic        ce_m;
    logic        ce_p;
    logic [7:0]  opmode;
    logic        busy;
    logic        done;
    logic [15:0] a;
    logic [15:0] b;

    dsp_mac_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ce_ab    (ce_ab),
        .ce_m     (ce_m),
        .ce_p     (ce_p),
        .opmode   (opmode),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Slice model: A/B input registers, M register, P register with X=M and Z in {0, P}.
    logic [15:0] a_r, b_r;
    logic [31:0] m_r;
    logic [47:0] p_r;

    always @(posedge clk) begin
        if (ce_ab) begin
            a_r <= a;
            b_r <= b;
        end
        if (ce_m) m_r <= a_r * b_r;
        if (ce_p) p_r <= (opmode[3:2] == 2'b10) ? p_r + {16'h0, m_r} : {16'h0, m_r};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ab_q[$];
    int          m_q[$];
    int          p_q[$];
    int          done_q[$];
    logic [7:0]  op_q[$];
    logic [47:0] pv_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (ce_ab) ab_q.push_back(cyc);
            if (ce_m)  m_q.push_back(cyc);
            if (ce_p) begin
                p_q.push_back(cyc);
                op_q.push_back(opmode);
            end
            if (done) begin
                done_q.push_back(cyc);
                pv_q.push_back(p_r);
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int t0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        ab_q.delete();
        m_q.delete();
        p_q.delete();
        done_q.delete();
        op_q.delete();
        pv_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [4:0] pat;
        rst = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0; in_valid = 1'b1;
        a = 16'd0; b = 16'd0;

        // 1. Reset with in_valid high: everything quiet.
        tick();
        settle();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ce_ab",    ce_ab,    1'b0);
        check("rst_ce_m",     ce_m,     1'b0);
        check("rst_ce_p",     ce_p,     1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        check("rst_opmode",   opmode,   8'h00);
        tick();
        settle();
        check("rst_busy2",    busy,     1'b0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        clear_logs();

        // 2. len=4, A=2, B=3, continuous valid -> P=24.
        a = 16'd2; b = 16'd3; in_valid = 1'b1; start = 1'b1; len = 8'd4; t0 = cyc;
        tick();
        start = 1'b0; len = 8'd0;
        settle();
        check("t2_busy", busy, 1'b1);
        repeat (10) tick();
        check("t2_n_ab",     ab_q.size(), 4);
        check("t2_ab_first", ab_q[0] - t0, 1);
        check("t2_ab_last",  ab_q[3] - t0, 4);
        check("t2_m_first",  m_q[0] - t0, 2);
        check("t2_p_first",  p_q[0] - t0, 3);
        check("t2_n_p",      op_q.size(), 4);
        check("t2_op0", op_q[0], 8'h01);
        check("t2_op1", op_q[1], 8'h09);
        check("t2_op2", op_q[2], 8'h09);
        check("t2_op3", op_q[3], 8'h09);
        check("t2_n_done",   done_q.size(), 1);
        check("t2_done_cyc", done_q[0] - t0, 7);
        check("t2_p",        pv_q[0], 48'd24);
        check("t2_idle",     busy, 1'b0);
        in_valid = 1'b0;
        clear_logs();

        // 3. len=3, valid pattern 1,0,1,0,1 -> gaps preserved through M and P.
        a = 16'd3; b = 16'd4; start = 1'b1; len = 8'd3; t0 = cyc;
        pat = 5'b10101;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("t3_n_ab", ab_q.size(), 3);
        check("t3_ab2",  ab_q[2] - t0, 5);
        check("t3_n_m",  m_q.size(), 3);
        check("t3_m0",   m_q[0] - t0, 2);
        check("t3_m1",   m_q[1] - t0, 4);
        check("t3_m2",   m_q[2] - t0, 6);
        check("t3_n_p",  p_q.size(), 3);
        check("t3_p0",   p_q[0] - t0, 3);
        check("t3_p1",   p_q[1] - t0, 5);
        check("t3_p2",   p_q[2] - t0, 7);
        check("t3_op0",  op_q[0], 8'h01);
        check("t3_op2",  op_q[2], 8'h09);
        check("t3_n_done",   done_q.size(), 1);
        check("t3_done_cyc", done_q[0] - t0, 8);
        check("t3_p",        pv_q[0], 48'd36);
        clear_logs();

        // 4. len=5, abort after two accepts; then a fresh len=1 job with A=B=1.
        a = 16'd2; b = 16'd2; in_valid = 1'b1; start = 1'b1; len = 8'd5; t0 = cyc;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        settle();
        check("t4_ready_abort", in_ready, 1'b0);
        check("t4_ab_abort",    ce_ab,    1'b0);
        tick();
        abort = 1'b0;
        settle();
        check("t4_busy_after", busy, 1'b0);
        repeat (6) tick();
        check("t4_n_ab",   ab_q.size(), 2);
        check("t4_n_m",    m_q.size(), 2);
        check("t4_m1",     m_q[1] - t0, 3);
        check("t4_n_p",    p_q.size(), 1);
        check("t4_p0",     p_q[0] - t0, 3);
        check("t4_n_done", done_q.size(), 0);
        clear_logs();
        a = 16'd1; b = 16'd1; start = 1'b1; len = 8'd1; t0 = cyc;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t4b_n_done",   done_q.size(), 1);
        check("t4b_done_cyc", done_q[0] - t0, 4);
        check("t4b_op0",      op_q[0], 8'h01);
        check("t4b_p",        pv_q[0], 48'd1);
        in_valid = 1'b0;
        clear_logs();

        // 5. start during ACC ignored; start with len=0 in IDLE ignored.
        a = 16'd1; b = 16'd1; start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; len = 8'd7;
        tick();
        start = 1'b0; len = 8'd0;
        settle();
        check("t5_busy", busy, 1'b1);
        check("t5_cnt",  dut.cnt, 8'd3);
        in_valid = 1'b1;
        repeat (12) tick();
        in_valid = 1'b0;
        check("t5_n_ab",   ab_q.size(), 3);
        check("t5_n_done", done_q.size(), 1);
        check("t5_p",      pv_q[0], 48'd3);
        clear_logs();
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        settle();
        check("t5_len0_busy", busy, 1'b0);
        check("t5_len0_cnt",  dut.cnt, 8'd0);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t5_len0_n_ab", ab_q.size(), 0);
        clear_logs();

        // 6. Back-to-back: start in the done cycle of a P=24 job; next job restarts at zero.
        a = 16'd2; b = 16'd3; in_valid = 1'b1; start = 1'b1; len = 8'd4; t0 = cyc;
        tick();
        start = 1'b0;
        repeat (6) tick();
        start = 1'b1; len = 8'd1; a = 16'd5; b = 16'd5;
        settle();
        check("t6_done_pulse", done, 1'b1);
        check("t6_idle_done",  busy, 1'b0);
        tick();
        start = 1'b0;
        settle();
        check("t6_busy2", busy, 1'b1);
        repeat (6) tick();
        in_valid = 1'b0;
        check("t6_n_done",    done_q.size(), 2);
        check("t6_p0",        pv_q[0], 48'd24);
        check("t6_done1_cyc", done_q[1] - t0, 11);
        check("t6_op4",       op_q[4], 8'h01);
        check("t6_p1",        pv_q[1], 48'd25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
